// File: rtl/exc_ctl.sv
// Exception/interrupt controller: latches IRQs and illegal-opcode events, sequences handler entry/return.
// Optional EXC_IRQ_MASK_EN adds a per-line interrupt mask register with write port.
module exc_ctl #(
  parameter int unsigned NUM_IRQ     = 4,
  parameter logic [31:0] VECTOR_ADDR = 32'h0000_0080,
  parameter int unsigned PC_W        = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_IRQ-1:0]         ext_irq,
  input  logic                       illOp,
  input  logic                       eret,
  input  logic [PC_W-1:0]            pc,
`ifdef EXC_IRQ_MASK_EN
  input  logic                       mask_we,
  input  logic [NUM_IRQ-1:0]         mask_wdata,
`endif
  output logic                       irq,
  output logic                       supervisorBit,
  output logic                       pc_redirect,
  output logic [PC_W-1:0]            redirect_pc,
  output logic [PC_W-1:0]            epc,
  output logic [4:0]                 cause,
  output logic [$clog2(NUM_IRQ)-1:0] irq_id,
  output logic [NUM_IRQ-1:0]         pending,
  output logic                       double_fault
);

  localparam int unsigned ID_W = $clog2(NUM_IRQ);
  localparam logic [4:0] CAUSE_INT = 5'd0;
  localparam logic [4:0] CAUSE_RI  = 5'd10;

  typedef enum logic [1:0] {USER, ENTER, HANDLER, RETURN} state_t;

  state_t              state, state_nx;
  logic [NUM_IRQ-1:0]  enable, req, clr;
  logic [ID_W-1:0]     winner;
  logic                hit;

  logic                irq_nx, sup_nx, redir_nx, df_nx;
  logic [PC_W-1:0]     rpc_nx, epc_nx;
  logic [4:0]          cause_nx;
  logic [ID_W-1:0]     id_nx;

`ifdef EXC_IRQ_MASK_EN
  logic [NUM_IRQ-1:0]  mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     mask <= '1;
    else if (mask_we) mask <= mask_wdata;
  end

  assign enable = mask;
`else
  assign enable = '1;
`endif

  assign req = (pending | ext_irq) & enable;

  always_comb begin
    winner = '0;
    hit    = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (req[i] && !hit) begin
        winner = ID_W'(i);
        hit    = 1'b1;
      end
    end
  end

  // Clear the serviced bit during the ENTER cycle; OR-ing ext_irq afterwards lets a set win.
  assign clr = (state == ENTER && cause == CAUSE_INT) ? (NUM_IRQ'(1) << irq_id) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= USER;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    epc_nx   = epc;
    cause_nx = cause;
    id_nx    = irq_id;
    df_nx    = double_fault;
    irq_nx   = 1'b0;
    sup_nx   = 1'b0;
    redir_nx = 1'b0;
    rpc_nx   = redirect_pc;
    case (state)
      USER: begin
        if (illOp) begin
          state_nx = ENTER;
          epc_nx   = pc;
          cause_nx = CAUSE_RI;
        end else if (hit) begin
          state_nx = ENTER;
          epc_nx   = pc;
          cause_nx = CAUSE_INT;
          id_nx    = winner;
        end
      end
      ENTER:   state_nx = HANDLER;
      HANDLER: begin
        if (illOp) df_nx    = 1'b1;
        if (eret)  state_nx = RETURN;
      end
      RETURN:  state_nx = USER;
      default: state_nx = USER;
    endcase
    // Outputs are decoded from the next state so they appear registered in the state they describe.
    case (state_nx)
      ENTER: begin
        irq_nx   = 1'b1;
        redir_nx = 1'b1;
        rpc_nx   = PC_W'(VECTOR_ADDR);
      end
      HANDLER: sup_nx = 1'b1;
      RETURN: begin
        sup_nx   = 1'b1;
        redir_nx = 1'b1;
        rpc_nx   = epc_nx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq           <= 1'b0;
      supervisorBit <= 1'b0;
      pc_redirect   <= 1'b0;
      redirect_pc   <= '0;
      epc           <= '0;
      cause         <= '0;
      irq_id        <= '0;
      pending       <= '0;
      double_fault  <= 1'b0;
    end else begin
      irq           <= irq_nx;
      supervisorBit <= sup_nx;
      pc_redirect   <= redir_nx;
      redirect_pc   <= rpc_nx;
      epc           <= epc_nx;
      cause         <= cause_nx;
      irq_id        <= id_nx;
      pending       <= (pending & ~clr) | ext_irq;
      double_fault  <= df_nx;
    end
  end

endmodule

// File: tb/tb_exc_ctl.sv
// Directed self-checking bench for exc_ctl; mask test runs only with EXC_IRQ_MASK_EN.
module tb_exc_ctl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  ext_irq;
  logic        illOp, eret;
  logic [31:0] pc;
  logic        irq, supervisorBit, pc_redirect, double_fault;
  logic [31:0] redirect_pc, epc;
  logic [4:0]  cause;
  logic [1:0]  irq_id;
  logic [3:0]  pending;
`ifdef EXC_IRQ_MASK_EN
  logic        mask_we;
  logic [3:0]  mask_wdata;
`endif

  int checks = 0;
  int errors = 0;

  exc_ctl #(.NUM_IRQ(4), .VECTOR_ADDR(32'h0000_0080), .PC_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .ext_irq(ext_irq), .illOp(illOp), .eret(eret), .pc(pc),
`ifdef EXC_IRQ_MASK_EN
    .mask_we(mask_we), .mask_wdata(mask_wdata),
`endif
    .irq(irq), .supervisorBit(supervisorBit), .pc_redirect(pc_redirect),
    .redirect_pc(redirect_pc), .epc(epc), .cause(cause), .irq_id(irq_id),
    .pending(pending), .double_fault(double_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".irq"}, 32'(irq), 32'd0);
    chk({tag, ".sup"}, 32'(supervisorBit), 32'd0);
    chk({tag, ".redir"}, 32'(pc_redirect), 32'd0);
    chk({tag, ".rpc"}, redirect_pc, 32'd0);
    chk({tag, ".epc"}, epc, 32'd0);
    chk({tag, ".cause"}, 32'(cause), 32'd0);
    chk({tag, ".id"}, 32'(irq_id), 32'd0);
    chk({tag, ".pend"}, 32'(pending), 32'd0);
    chk({tag, ".df"}, 32'(double_fault), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; ext_irq = '0; illOp = 1'b0; eret = 1'b0; pc = '0;
`ifdef EXC_IRQ_MASK_EN
    mask_we = 1'b0; mask_wdata = '0;
`endif
    #3;
    chk_zero("rst");
    @(negedge clk); reset_n = 1'b1;
    cyc();
    chk_zero("idle");

    // single interrupt on line 2
    ext_irq = 4'b0100; pc = 32'h40;
    cyc();
    ext_irq = '0; pc = 32'h80;
    chk("t1.irq", 32'(irq), 32'd1);
    chk("t1.redir", 32'(pc_redirect), 32'd1);
    chk("t1.rpc", redirect_pc, 32'h80);
    chk("t1.epc", epc, 32'h40);
    chk("t1.cause", 32'(cause), 32'd0);
    chk("t1.id", 32'(irq_id), 32'd2);
    chk("t1.sup0", 32'(supervisorBit), 32'd0);
    cyc();
    chk("t1.sup1", 32'(supervisorBit), 32'd1);
    chk("t1.pend", 32'(pending), 32'd0);
    chk("t1.irq0", 32'(irq), 32'd0);
    chk("t1.redir0", 32'(pc_redirect), 32'd0);
    cyc();
    chk("t1.hold", 32'(supervisorBit), 32'd1);

    // eret return sequence
    eret = 1'b1;
    cyc();
    eret = 1'b0;
    chk("ret.redir", 32'(pc_redirect), 32'd1);
    chk("ret.rpc", redirect_pc, 32'h40);
    chk("ret.sup", 32'(supervisorBit), 32'd1);
    cyc();
    chk("ret.sup0", 32'(supervisorBit), 32'd0);
    chk("ret.irq0", 32'(irq), 32'd0);
    chk("ret.redir0", 32'(pc_redirect), 32'd0);

    // illOp beats simultaneous interrupt 0
    illOp = 1'b1; ext_irq = 4'b0001; pc = 32'h100;
    cyc();
    illOp = 1'b0; ext_irq = '0;
    chk("t2.irq", 32'(irq), 32'd1);
    chk("t2.cause", 32'(cause), 32'd10);
    chk("t2.epc", epc, 32'h100);
    chk("t2.id", 32'(irq_id), 32'd2);
    chk("t2.pend", 32'(pending), 32'b0001);
    cyc();
    chk("t2.pendh", 32'(pending), 32'b0001);
    eret = 1'b1;
    cyc();
    eret = 1'b0; pc = 32'h200;
    chk("t2.rpc", redirect_pc, 32'h100);
    cyc();
    chk("t2.user", 32'(supervisorBit), 32'd0);
    cyc();
    chk("t2b.irq", 32'(irq), 32'd1);
    chk("t2b.cause", 32'(cause), 32'd0);
    chk("t2b.id", 32'(irq_id), 32'd0);
    chk("t2b.epc", epc, 32'h200);
    cyc();
    chk("t2b.pend", 32'(pending), 32'd0);

    // double fault in handler, interrupt accumulating in handler
    illOp = 1'b1;
    cyc();
    illOp = 1'b0;
    chk("df.set", 32'(double_fault), 32'd1);
    chk("df.epc", epc, 32'h200);
    chk("df.cause", 32'(cause), 32'd0);
    chk("df.sup", 32'(supervisorBit), 32'd1);
    chk("df.redir", 32'(pc_redirect), 32'd0);
    ext_irq = 4'b1000;
    cyc();
    ext_irq = '0;
    chk("hp.pend", 32'(pending), 32'b1000);
    chk("hp.irq", 32'(irq), 32'd0);
    chk("df.sticky", 32'(double_fault), 32'd1);
    eret = 1'b1;
    cyc();
    eret = 1'b0; pc = 32'h300;
    chk("hp.redir", 32'(pc_redirect), 32'd1);
    chk("hp.rpc", redirect_pc, 32'h200);
    cyc();
    chk("hp.user", 32'(supervisorBit), 32'd0);
    chk("hp.irq0", 32'(irq), 32'd0);
    chk("hp.pendu", 32'(pending), 32'b1000);
    cyc();
    chk("hp.irq", 32'(irq), 32'd1);
    chk("hp.id", 32'(irq_id), 32'd3);
    chk("hp.epc", epc, 32'h300);
    chk("df.keep", 32'(double_fault), 32'd1);

    // asynchronous reset in the middle of ENTER
    #2 reset_n = 1'b0;
    #1 chk_zero("arst");
    @(negedge clk); reset_n = 1'b1;
    cyc();
    chk_zero("arst2");

`ifdef EXC_IRQ_MASK_EN
    mask_we = 1'b1; mask_wdata = 4'b1110;
    cyc();
    mask_we = 1'b0;
    ext_irq = 4'b0001; pc = 32'h500;
    cyc();
    ext_irq = '0;
    chk("msk.noirq", 32'(irq), 32'd0);
    chk("msk.pend", 32'(pending), 32'b0001);
    cyc();
    chk("msk.noirq2", 32'(irq), 32'd0);
    mask_we = 1'b1; mask_wdata = 4'b1111;
    cyc();
    mask_we = 1'b0;
    chk("msk.noirq3", 32'(irq), 32'd0);
    cyc();
    chk("msk.irq", 32'(irq), 32'd1);
    chk("msk.id", 32'(irq_id), 32'd0);
    chk("msk.epc", epc, 32'h500);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_ctl.md
Name: exc_ctl

Overview:
- Exception/interrupt controller: the producer side of the `irq`/`supervisorBit` inputs of the control decoder, and the consumer of its `illOp` output.
- Latches external interrupt requests and illegal-opcode events, and arbitrates between them.
- Sequences handler entry and return: drives the PC redirect, saves EPC and cause, and tracks supervisor mode.
- Sits beside the decoder and the PC register in the single-cycle core.

Parameters:
- NUM_IRQ, 4: number of external interrupt lines.
- VECTOR_ADDR, 32'h0000_0080: handler entry PC.
- PC_W, 32: PC/EPC width.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- ext_irq  in  NUM_IRQ  level interrupt requests, synchronous to clk.
- illOp  in  1  illegal opcode flag from the decoder.
- eret  in  1  return-from-handler strobe, decoded by the datapath.
- pc  in  PC_W  PC of the instruction in the current cycle.
- irq  out  1  to decoder; forces the link-write sequence.
- supervisorBit  out  1  1 while in handler.
- pc_redirect  out  1  PC mux select; load redirect_pc this cycle.
- redirect_pc  out  PC_W  target PC when pc_redirect=1.
- epc  out  PC_W  saved exception PC.
- cause  out  5  5'd0 = interrupt, 5'd10 = reserved instruction.
- irq_id  out  $clog2(NUM_IRQ)  index of the serviced interrupt.
- pending  out  NUM_IRQ  sticky pending bits.
- double_fault  out  1  sticky; illOp seen while in handler.

Behaviour:
- Reset (async, reset_n=0):
  - state=USER.
  - irq, supervisorBit, pc_redirect, double_fault = 0.
  - redirect_pc, epc, cause, irq_id, pending = 0.
- Pending register:
  - pending[i] <= pending[i] | ext_irq[i] every cycle.
  - The serviced bit is cleared on entry to ENTER.
  - Set and clear in the same cycle on the same bit: set wins (bit stays 1).
- FSM states: USER, ENTER, HANDLER, RETURN. All outputs are registered from state/data regs.
- USER (supervisorBit=0, irq=0, pc_redirect=0):
  - Event at cycle t if illOp=1 or (pending|ext_irq)&enable != 0.
  - Priority: illOp over interrupts; among interrupts, lowest index wins.
  - On event, go to ENTER at t+1. At that edge:
    - epc <= pc(t).
    - cause <= 10 if illOp, else 0.
    - irq_id <= winner index (illOp leaves irq_id unchanged).
  - eret in USER: ignored.
- ENTER (exactly 1 cycle):
  - irq=1, supervisorBit=0, so the decoder performs its link write.
  - pc_redirect=1, redirect_pc=VECTOR_ADDR.
  - Next state HANDLER.
- HANDLER (supervisorBit=1, irq=0, pc_redirect=0):
  - New interrupts only accumulate in pending; no nesting.
  - illOp=1: double_fault <= 1 (sticky until reset); state unchanged; epc/cause unchanged.
  - eret=1: next state RETURN.
- RETURN (1 cycle):
  - pc_redirect=1, redirect_pc=epc, supervisorBit=1.
  - Next state USER.
  - A request still pending on entry to USER raises a new event in the first USER cycle (back-to-back service; min 4 cycles per round trip).
- Latency:
  - Event to redirect: 1 cycle.
  - eret to redirect: 1 cycle.
  - eret to supervisorBit=0: 2 cycles.
- Simultaneous illOp and interrupt in USER:
  - illOp is serviced.
  - The interrupt stays pending and is serviced after the return.
- Reset mid-ENTER/HANDLER/RETURN: immediate return to USER with all reset values; pending is lost.

Optional Feature:
- Macro: EXC_IRQ_MASK_EN.
- Defined:
  - Adds ports mask_we (in, 1) and mask_wdata (in, NUM_IRQ).
  - Mask register resets to all ones; written when mask_we=1 in any state.
  - enable = mask.
  - Masked lines still set pending; they are serviced once unmasked.
- Undefined:
  - No mask ports; enable = all ones.

Test Plan:
- ext_irq=4'b0100 for 1 cycle with pc=0x40 in USER:
  - next cycle irq=1, pc_redirect=1, redirect_pc=0x80, epc=0x40, cause=0, irq_id=2;
  - following cycle supervisorBit=1, pending=0.
- illOp=1 and ext_irq=4'b0001 in the same cycle, pc=0x100:
  - ENTER with cause=10, epc=0x100;
  - after eret and RETURN, a second entry with cause=0, irq_id=0 and epc equal to the pc at that time.
- In HANDLER, pulse eret:
  - next cycle pc_redirect=1, redirect_pc=epc, supervisorBit=1;
  - cycle after, supervisorBit=0, irq=0.
- illOp=1 while in HANDLER: double_fault=1 and stays 1; epc/cause/state unchanged; eret still returns normally.
- ext_irq=4'b1000 while in HANDLER: pending=4'b1000 and no irq; serviced on the cycle after return to USER (irq_id=3).
- Assert reset_n=0 during ENTER: outputs go to 0 asynchronously. With EXC_IRQ_MASK_EN, mask=4'b1110: ext_irq[0] only pends and enters once unmasked.
